// File: rtl/pixel_iteration_controller.sv
// Escape-time iteration sequencer: feeds one pixel_calculator with z/c operands,
// tracks the iteration count and reports escape, cap or calculator-stall results.
module pixel_iteration_controller #(
  parameter int WIDTH      = 22,
  parameter int FRACTIONAL = 11,
  parameter int MAX_ITER   = 255,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic signed [WIDTH-1:0] z0_real,
  input  logic signed [WIDTH-1:0] z0_imag,
  input  logic signed [WIDTH-1:0] c_real,
  input  logic signed [WIDTH-1:0] c_imag,
  output logic                    calc_start,
  output logic signed [WIDTH-1:0] z_real_out,
  output logic signed [WIDTH-1:0] z_imag_out,
  output logic signed [WIDTH-1:0] c_real_out,
  output logic signed [WIDTH-1:0] c_imag_out,
  output logic [7:0]              iteration_out,
  input  logic signed [WIDTH-1:0] z_real_in,
  input  logic signed [WIDTH-1:0] z_imag_in,
  input  logic signed [WIDTH-1:0] size_squared_in,
  input  logic                    calc_done,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [7:0]              result_iter,
  output logic                    result_escaped,
  output logic                    result_error
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_t;

  localparam int                      WD_W     = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0]         WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]         WD_ONE   = WD_W'(1);
  localparam logic [7:0]              ITER_CAP = 8'(MAX_ITER);
  localparam logic signed [WIDTH-1:0] ESC      = WIDTH'(4 << FRACTIONAL);

  // A negative |z|^2 can only come from calculator overflow, so it counts as escape.
  function automatic logic is_escape(input logic signed [WIDTH-1:0] s);
    return s[WIDTH-1] || (s > ESC);
  endfunction

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] z_re_q, z_re_d, z_im_q, z_im_d;
  logic signed [WIDTH-1:0] c_re_q, c_re_d, c_im_q, c_im_d;
  logic signed [WIDTH-1:0] size_sq_q, size_sq_d;
  logic signed [WIDTH-1:0] zo_re_q, zo_re_d, zo_im_q, zo_im_d;
  logic [7:0]              iter_q, iter_d, it_out_q, it_out_d;
  logic [7:0]              res_iter_q, res_iter_d;
  logic                    res_esc_q, res_esc_d, res_err_q, res_err_d;
  logic [WD_W-1:0]         wdog_q, wdog_d;

  always_comb begin
    state_d    = state_q;
    z_re_d     = z_re_q;
    z_im_d     = z_im_q;
    c_re_d     = c_re_q;
    c_im_d     = c_im_q;
    size_sq_d  = size_sq_q;
    zo_re_d    = zo_re_q;
    zo_im_d    = zo_im_q;
    iter_d     = iter_q;
    it_out_d   = it_out_q;
    res_iter_d = res_iter_q;
    res_esc_d  = res_esc_q;
    res_err_d  = res_err_q;
    wdog_d     = wdog_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          z_re_d  = z0_real;
          z_im_d  = z0_imag;
          c_re_d  = c_real;
          c_im_d  = c_imag;
          iter_d  = 8'd0;
          wdog_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // calc_done takes priority over a watchdog expiring in the same cycle.
        if (calc_done) begin
          z_re_d    = z_real_in;
          z_im_d    = z_imag_in;
          size_sq_d = size_squared_in;
          iter_d    = iter_q + 8'd1;
          state_d   = CHECK;
        end else if (wdog_q == WD_LAST) begin
          res_iter_d = iter_q;
          res_esc_d  = 1'b0;
          res_err_d  = 1'b1;
          state_d    = DONE;
        end else begin
          wdog_d = wdog_q + WD_ONE;
        end
      end
      CHECK: begin
        if (is_escape(size_sq_q)) begin
          res_iter_d = iter_q;
          res_esc_d  = 1'b1;
          res_err_d  = 1'b0;
          state_d    = DONE;
        end else if (iter_q == ITER_CAP) begin
          res_iter_d = iter_q;
          res_esc_d  = 1'b0;
          res_err_d  = 1'b0;
          state_d    = DONE;
        end else begin
          state_d = ISSUE;
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Operand outputs only move when a new iteration is about to be issued.
    if (state_d == ISSUE) begin
      zo_re_d  = z_re_d;
      zo_im_d  = z_im_d;
      it_out_d = iter_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      z_re_q     <= '0;
      z_im_q     <= '0;
      c_re_q     <= '0;
      c_im_q     <= '0;
      size_sq_q  <= '0;
      zo_re_q    <= '0;
      zo_im_q    <= '0;
      iter_q     <= '0;
      it_out_q   <= '0;
      res_iter_q <= '0;
      res_esc_q  <= 1'b0;
      res_err_q  <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      z_re_q     <= z_re_d;
      z_im_q     <= z_im_d;
      c_re_q     <= c_re_d;
      c_im_q     <= c_im_d;
      size_sq_q  <= size_sq_d;
      zo_re_q    <= zo_re_d;
      zo_im_q    <= zo_im_d;
      iter_q     <= iter_d;
      it_out_q   <= it_out_d;
      res_iter_q <= res_iter_d;
      res_esc_q  <= res_esc_d;
      res_err_q  <= res_err_d;
      wdog_q     <= wdog_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign calc_start     = (state_q == ISSUE);
  assign result_valid   = (state_q == DONE);
  assign z_real_out     = zo_re_q;
  assign z_imag_out     = zo_im_q;
  assign c_real_out     = c_re_q;
  assign c_imag_out     = c_im_q;
  assign iteration_out  = it_out_q;
  assign result_iter    = res_iter_q;
  assign result_escaped = res_esc_q;
  assign result_error   = res_err_q;

endmodule

// File: tb/tb_pixel_iteration_controller.sv
// Bench for pixel_iteration_controller: behavioural calculator with programmable
// latency, a table of directed points, hand-written corner sequences and random points.
module tb_pixel_iteration_controller;
  localparam int W    = 22;
  localparam int F    = 11;
  localparam int MAXI = 255;
  localparam int TO   = 64;
  localparam logic signed [W-1:0] ESC = 22'sd8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, req_valid, req_ready, calc_start, calc_done;
  logic                result_valid, result_ready, result_escaped, result_error;
  logic signed [W-1:0] z0_real, z0_imag, c_real, c_imag;
  logic signed [W-1:0] z_real_out, z_imag_out, c_real_out, c_imag_out;
  logic signed [W-1:0] z_real_in, z_imag_in, size_squared_in;
  logic [7:0]          iteration_out, result_iter;

  pixel_iteration_controller #(.WIDTH(W), .FRACTIONAL(F), .MAX_ITER(MAXI), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .z0_real(z0_real), .z0_imag(z0_imag), .c_real(c_real), .c_imag(c_imag),
    .calc_start(calc_start), .z_real_out(z_real_out), .z_imag_out(z_imag_out),
    .c_real_out(c_real_out), .c_imag_out(c_imag_out), .iteration_out(iteration_out),
    .z_real_in(z_real_in), .z_imag_in(z_imag_in), .size_squared_in(size_squared_in),
    .calc_done(calc_done), .result_valid(result_valid), .result_ready(result_ready),
    .result_iter(result_iter), .result_escaped(result_escaped), .result_error(result_error)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One step of z <- z^2 + c in fixed point, returning the new z and |z|^2.
  function automatic void calc_step(input logic signed [W-1:0] zr, zi, cr, ci,
                                    output logic signed [W-1:0] nr, ni, sz);
    longint a, b, r, i;
    a = zr;
    b = zi;
    r = ((a * a - b * b) >>> F) + longint'(cr);
    i = ((2 * a * b) >>> F) + longint'(ci);
    nr = W'(r);
    ni = W'(i);
    a = nr;
    b = ni;
    sz = W'((a * a + b * b) >>> F);
  endfunction

  // Escape-time answer for a point, computed directly from the iteration rules.
  function automatic void ref_point(input logic signed [W-1:0] zr, zi, cr, ci,
                                    output int it, output bit esc);
    logic signed [W-1:0] r, i, s;
    r = zr;
    i = zi;
    it = 0;
    esc = 1'b0;
    while (it < MAXI && !esc) begin
      calc_step(r, i, cr, ci, r, i, s);
      it++;
      if (s > ESC || s[W-1]) esc = 1'b1;
    end
  endfunction

  // Knobs written by the test process, read by the calculator model.
  int                  k_lat = 3;
  bit                  k_mute = 1'b0;
  bit                  k_force = 1'b0;
  logic signed [W-1:0] k_fval = '0;
  logic signed [W-1:0] k_z0r = '0, k_z0i = '0, k_cr = '0, k_ci = '0;
  int                  pt_id = 0;
  int                  spur_cnt = 0;

  // Calculator model state (written only by the model process).
  int                  seen_id, spur_seen, pending, issue_idx;
  logic signed [W-1:0] ez_r, ez_i, nzr, nzi, nsz;

  initial begin
    calc_done = 1'b0;
    z_real_in = '0;
    z_imag_in = '0;
    size_squared_in = '0;
    seen_id = 0;
    spur_seen = 0;
    pending = 0;
    issue_idx = 0;
    ez_r = '0;
    ez_i = '0;
    nzr = '0;
    nzi = '0;
    nsz = '0;
    forever begin
      @(negedge clk);
      calc_done = 1'b0;
      if (pt_id != seen_id) begin
        seen_id = pt_id;
        issue_idx = 0;
        ez_r = k_z0r;
        ez_i = k_z0i;
      end
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        calc_done = 1'b1;
      end else if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          calc_done = 1'b1;
          z_real_in = nzr;
          z_imag_in = nzi;
          size_squared_in = k_force ? k_fval : nsz;
        end
      end
      if (calc_start === 1'b1) begin
        chk("iteration_out", iteration_out, issue_idx);
        chk("z_real_out", z_real_out, ez_r);
        chk("z_imag_out", z_imag_out, ez_i);
        chk("c_real_out", c_real_out, k_cr);
        chk("c_imag_out", c_imag_out, k_ci);
        calc_step(z_real_out, z_imag_out, c_real_out, c_imag_out, nzr, nzi, nsz);
        ez_r = nzr;
        ez_i = nzi;
        issue_idx++;
        if (!k_mute) pending = k_lat;
      end
    end
  end

  task automatic send_point(input logic signed [W-1:0] zr, zi, cr, ci);
    int g = 0;
    while (req_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("req_ready_before_send", req_ready, 1);
    z0_real = zr;
    z0_imag = zi;
    c_real = cr;
    c_imag = ci;
    k_z0r = zr;
    k_z0i = zi;
    k_cr = cr;
    k_ci = ci;
    pt_id++;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge until result_valid is seen.
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (result_valid !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("result_valid_seen", result_valid, 1);
  endtask

  task automatic accept();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_calc_start"}, calc_start, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_iteration_out"}, iteration_out, 0);
    chk({tag, "_z_real_out"}, z_real_out, 0);
    chk({tag, "_z_imag_out"}, z_imag_out, 0);
    chk({tag, "_c_real_out"}, c_real_out, 0);
    chk({tag, "_c_imag_out"}, c_imag_out, 0);
    chk({tag, "_result_iter"}, result_iter, 0);
    chk({tag, "_result_escaped"}, result_escaped, 0);
    chk({tag, "_result_error"}, result_error, 0);
  endtask

  typedef struct {
    logic signed [W-1:0] zr, zi, cr, ci;
    int                  lat;
    bit                  force_en;
    logic signed [W-1:0] fval;
    int                  exp_iter;
    bit                  exp_esc;
    bit                  exp_err;
    int                  exp_cyc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    int cyc, eit, lat;
    bit eesc;
    logic signed [W-1:0] rzr, rzi, rcr, rci;

    // Iterations complete at n*(L+2) edges after the accepting edge.
    vecs[0] = '{22'sd0, 22'sd0, 22'sd0, 22'sd0, 3, 1'b0, 22'sd0, 255, 1'b0, 1'b0, 1275};
    vecs[1] = '{22'sd0, 22'sd0, 22'sd1024, 22'sd1024, 3, 1'b0, 22'sd0, 5, 1'b1, 1'b0, 25};
    vecs[2] = '{22'sd0, 22'sd0, 22'sd0, 22'sd0, 3, 1'b1, 22'sd8192, 255, 1'b0, 1'b0, 1275};
    vecs[3] = '{22'sd0, 22'sd0, 22'sd0, 22'sd0, 3, 1'b1, 22'sd8193, 1, 1'b1, 1'b0, 5};
    vecs[4] = '{22'sd0, 22'sd0, 22'sd0, 22'sd0, 3, 1'b1, -22'sd1, 1, 1'b1, 1'b0, 5};

    rst = 1'b1;
    req_valid = 1'b0;
    result_ready = 1'b0;
    z0_real = '0;
    z0_imag = '0;
    c_real = '0;
    c_imag = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      k_lat = vecs[v].lat;
      k_force = vecs[v].force_en;
      k_fval = vecs[v].fval;
      send_point(vecs[v].zr, vecs[v].zi, vecs[v].cr, vecs[v].ci);
      wait_result(cyc);
      chk($sformatf("vec%0d_iter", v), result_iter, vecs[v].exp_iter);
      chk($sformatf("vec%0d_escaped", v), result_escaped, vecs[v].exp_esc);
      chk($sformatf("vec%0d_error", v), result_error, vecs[v].exp_err);
      chk($sformatf("vec%0d_latency", v), cyc, vecs[v].exp_cyc);
      chk($sformatf("vec%0d_issues", v), issue_idx, vecs[v].exp_iter);
      accept();
    end
    k_force = 1'b0;

    // Calculator never answers: watchdog abort, then spurious calc_done pulses.
    k_mute = 1'b1;
    send_point(22'sd0, 22'sd0, 22'sd0, 22'sd0);
    wait_result(cyc);
    chk("timeout_latency", cyc, TO + 1);
    chk("timeout_error", result_error, 1);
    chk("timeout_iter", result_iter, 0);
    chk("timeout_escaped", result_escaped, 0);
    spur_cnt++;
    repeat (3) @(negedge clk);
    chk("spur_done_valid", result_valid, 1);
    chk("spur_done_error", result_error, 1);
    chk("spur_done_req_ready", req_ready, 0);
    accept();
    chk("spur_idle_req_ready_before", req_ready, 1);
    spur_cnt++;
    repeat (3) @(negedge clk);
    chk("spur_idle_req_ready", req_ready, 1);
    chk("spur_idle_calc_start", calc_start, 0);
    chk("spur_idle_result_valid", result_valid, 0);
    k_mute = 1'b0;

    // Downstream back-pressure in DONE, with req_valid asserted meanwhile.
    k_lat = 3;
    send_point(22'sd0, 22'sd0, 22'sd1024, 22'sd1024);
    wait_result(cyc);
    z0_real = 22'sd777;
    c_real = -22'sd333;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_result_valid", result_valid, 1);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_result_iter", result_iter, 5);
      chk("hold_result_escaped", result_escaped, 1);
      chk("hold_calc_start", calc_start, 0);
    end
    req_valid = 1'b0;
    accept();
    chk("after_accept_req_ready", req_ready, 1);
    send_point(22'sd0, 22'sd0, 22'sd1024, 22'sd1024);
    chk("next_point_issued", calc_start, 1);
    wait_result(cyc);
    chk("next_point_iter", result_iter, 5);
    chk("next_point_latency", cyc, 25);
    accept();

    // Reset while a calc_done is still due; the late pulse must be ignored.
    send_point(22'sd0, 22'sd0, 22'sd1024, 22'sd1024);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_req_ready", req_ready, 1);
    chk("post_reset_calc_start", calc_start, 0);
    chk("post_reset_result_valid", result_valid, 0);
    repeat (2) @(negedge clk);
    chk("post_reset_still_idle", req_ready, 1);
    send_point(22'sd0, 22'sd0, 22'sd1024, 22'sd1024);
    wait_result(cyc);
    chk("post_reset_iter", result_iter, 5);
    chk("post_reset_escaped", result_escaped, 1);
    chk("post_reset_latency", cyc, 25);
    accept();

    // Random points against the escape-time reference.
    for (int n = 0; n < 12; n++) begin
      lat = $urandom_range(1, 4);
      rcr = W'(int'($urandom_range(0, 8191)) - 4096);
      rci = W'(int'($urandom_range(0, 8191)) - 4096);
      if ($urandom_range(0, 2) == 0) begin
        rzr = W'(int'($urandom_range(0, 4095)) - 2048);
        rzi = W'(int'($urandom_range(0, 4095)) - 2048);
      end else begin
        rzr = '0;
        rzi = '0;
      end
      ref_point(rzr, rzi, rcr, rci, eit, eesc);
      k_lat = lat;
      send_point(rzr, rzi, rcr, rci);
      wait_result(cyc);
      chk($sformatf("rand%0d_iter", n), result_iter, eit);
      chk($sformatf("rand%0d_escaped", n), result_escaped, eesc);
      chk($sformatf("rand%0d_error", n), result_error, 0);
      chk($sformatf("rand%0d_latency", n), cyc, eit * (lat + 2));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk($sformatf("rand%0d_valid_held", n), result_valid, 1);
      accept();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
